// File: rtl/cpu_accel_responder_if.sv
// CPU accelerator port plus command/result streams of the accelerator responder.
// The responder takes the slave side; the CPU/accelerator environment drives master.
interface cpu_accel_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   accel_id;
    logic                  accel_can_write;
    logic                  accel_write_enable;
    logic [DATA_WIDTH-1:0] accel_write_data;
    logic                  accel_can_read;
    logic                  accel_read_enable;
    logic [DATA_WIDTH-1:0] accel_read_data;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  res_valid;
    logic                  res_ready;
    logic [ID_WIDTH-1:0]   res_id;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  error;

    modport slave (
        input  accel_id, accel_write_enable, accel_write_data,
        input  accel_read_enable, cmd_ready,
        input  res_valid, res_id, res_data,
        output accel_can_write, accel_can_read, accel_read_data,
        output cmd_valid, cmd_id, cmd_data, res_ready, error
    );

    modport master (
        output accel_id, accel_write_enable, accel_write_data,
        output accel_read_enable, cmd_ready,
        output res_valid, res_id, res_data,
        input  accel_can_write, accel_can_read, accel_read_data,
        input  cmd_valid, cmd_id, cmd_data, res_ready, error
    );
endinterface

// File: rtl/cpu_accel_responder.sv
// Accelerator-side endpoint of the CPU accelerator port: command FIFO out,
// in-order result FIFO back, reads gated by the id at the result head.
module cpu_accel_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int RES_DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    cpu_accel_responder_if.slave bus
);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam logic [CW:0] CMD_FULL = (CW+1)'(CMD_DEPTH);
    localparam logic [RW:0] RES_FULL = (RW+1)'(RES_DEPTH);

    logic [ID_WIDTH-1:0]   cmd_id_q   [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] cmd_data_q [CMD_DEPTH];
    logic [ID_WIDTH-1:0]   res_id_q   [RES_DEPTH];
    logic [DATA_WIDTH-1:0] res_data_q [RES_DEPTH];

    logic [CW-1:0] cmd_rd, cmd_wr;
    logic [CW:0]   cmd_cnt;
    logic [RW-1:0] res_rd, res_wr;
    logic [RW:0]   res_cnt;
    logic          err_q;

    logic cmd_nempty, can_write, res_nempty, res_space, can_read;
    logic cmd_push, cmd_pop, res_push, res_pop, violation;

    assign cmd_nempty = (cmd_cnt != '0);
    assign can_write  = (cmd_cnt != CMD_FULL);
    assign res_nempty = (res_cnt != '0);
    assign res_space  = (res_cnt != RES_FULL);
    assign can_read   = res_nempty && (res_id_q[res_rd] == bus.accel_id);

    // A full FIFO rejects a push even when a pop happens on the same edge.
    assign cmd_push = bus.accel_write_enable && can_write;
    assign cmd_pop  = cmd_nempty && bus.cmd_ready;
    assign res_push = bus.res_valid && res_space;
    assign res_pop  = bus.accel_read_enable && can_read;

    assign violation = (bus.accel_write_enable && !can_write)
                    || (bus.accel_read_enable && !can_read);

    assign bus.accel_can_write = can_write;
    assign bus.accel_can_read  = can_read;
    assign bus.accel_read_data = res_nempty ? res_data_q[res_rd] : '0;
    assign bus.cmd_valid       = cmd_nempty;
    assign bus.cmd_id          = cmd_id_q[cmd_rd];
    assign bus.cmd_data        = cmd_data_q[cmd_rd];
    assign bus.res_ready       = res_space;
    assign bus.error           = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_rd  <= '0;
            cmd_wr  <= '0;
            cmd_cnt <= '0;
            res_rd  <= '0;
            res_wr  <= '0;
            res_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
            if (cmd_pop)  cmd_rd <= cmd_rd + 1'b1;
            if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
            else if (cmd_pop && !cmd_push) cmd_cnt <= cmd_cnt - 1'b1;

            if (res_push) res_wr <= res_wr + 1'b1;
            if (res_pop)  res_rd <= res_rd + 1'b1;
            if (res_push && !res_pop)      res_cnt <= res_cnt + 1'b1;
            else if (res_pop && !res_push) res_cnt <= res_cnt - 1'b1;

            if (violation) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: stale slots are unreachable once counts clear.
    always_ff @(posedge clk) begin
        if (rst && cmd_push) begin
            cmd_id_q[cmd_wr]   <= bus.accel_id;
            cmd_data_q[cmd_wr] <= bus.accel_write_data;
        end
        if (rst && res_push) begin
            res_id_q[res_wr]   <= bus.res_id;
            res_data_q[res_wr] <= bus.res_data;
        end
    end
endmodule

// File: tb/tb_cpu_accel_responder.sv
// Bench for cpu_accel_responder: directed steps then random traffic,
// checked against a queue-based model of the port.
module tb_cpu_accel_responder;
    localparam int DW = 16;
    localparam int IW = 4;
    localparam int CD = 4;
    localparam int RD = 4;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_accel_responder_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

    cpu_accel_responder #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .CMD_DEPTH(CD), .RES_DEPTH(RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    ent_t cq[$];
    ent_t rq[$];
    logic merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, evaluated on the inputs held across that edge.
    task automatic model_edge();
        bit cw, cr, cpush, cpop, rpush, rpop;
        if (!rst) begin
            cq.delete();
            rq.delete();
            merr = 1'b0;
        end else begin
            cw    = cq.size() < CD;
            cr    = rq.size() != 0 && rq[0].id == bus.accel_id;
            cpush = bus.accel_write_enable && cw;
            cpop  = cq.size() != 0 && bus.cmd_ready;
            rpush = bus.res_valid && rq.size() < RD;
            rpop  = bus.accel_read_enable && cr;
            if ((bus.accel_write_enable && !cw) ||
                (bus.accel_read_enable && !cr)) merr = 1'b1;
            if (cpop) void'(cq.pop_front());
            if (rpop) void'(rq.pop_front());
            if (cpush) cq.push_back('{bus.accel_id, bus.accel_write_data});
            if (rpush) rq.push_back('{bus.res_id, bus.res_data});
        end
    endtask

    task automatic check_all();
        bit cr;
        cr = rq.size() != 0 && rq[0].id == bus.accel_id;
        chk("can_write", 32'(bus.accel_can_write), 32'(cq.size() != CD));
        chk("cmd_valid", 32'(bus.cmd_valid), 32'(cq.size() != 0));
        if (cq.size() != 0) begin
            chk("cmd_id", 32'(bus.cmd_id), 32'(cq[0].id));
            chk("cmd_data", 32'(bus.cmd_data), 32'(cq[0].d));
        end
        chk("res_ready", 32'(bus.res_ready), 32'(rq.size() != RD));
        chk("can_read", 32'(bus.accel_can_read), 32'(cr));
        chk("read_data", 32'(bus.accel_read_data),
            rq.size() != 0 ? 32'(rq[0].d) : 32'h0);
        chk("error", 32'(bus.error), 32'(merr));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.accel_write_enable = 1'b0;
        bus.accel_read_enable  = 1'b0;
        bus.res_valid          = 1'b0;
        bus.cmd_ready          = 1'b0;
    endtask

    task automatic wr(input logic [IW-1:0] id, input logic [DW-1:0] d);
        bus.accel_id           = id;
        bus.accel_write_data   = d;
        bus.accel_write_enable = 1'b1;
        tick();
        bus.accel_write_enable = 1'b0;
    endtask

    task automatic rs(input logic [IW-1:0] id, input logic [DW-1:0] d);
        bus.res_id    = id;
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        tick();
        bus.res_valid = 1'b0;
    endtask

    int pushed;

    initial begin
        rst = 1'b0;
        idle();
        bus.accel_id         = '0;
        bus.accel_write_data = '0;
        bus.res_id           = '0;
        bus.res_data         = '0;

        // Reset, with writes attempted while held.
        bus.accel_write_enable = 1'b1;
        bus.res_valid          = 1'b1;
        tick();
        tick();
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'h0);
        idle();
        rst = 1'b1;
        tick();
        chk("rst_can_write", 32'(bus.accel_can_write), 32'h1);
        chk("rst_res_ready", 32'(bus.res_ready), 32'h1);

        // Command ordering and full boundary.
        wr(4'd3, 16'h0011);
        wr(4'd5, 16'h0022);
        wr(4'd3, 16'h0033);
        wr(4'd1, 16'h0044);
        chk("full_can_write", 32'(bus.accel_can_write), 32'h0);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drained", 32'(bus.cmd_valid), 32'h0);

        // Full FIFO: pop and rejected push on the same edge.
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(4'(i), 16'(16'h0100 + i));
        bus.cmd_ready          = 1'b1;
        bus.accel_write_enable = 1'b1;
        bus.accel_write_data   = 16'hdead;
        tick();
        idle();
        chk("full_err", 32'(bus.error), 32'h1);
        chk("full_pop", 32'(bus.accel_can_write), 32'h1);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();

        // Result id gating.
        rs(4'd2, 16'h002a);
        rs(4'd7, 16'd42);
        bus.accel_id = 4'd7;
        tick();
        chk("gate_blocked", 32'(bus.accel_can_read), 32'h0);
        chk("gate_head", 32'(bus.accel_read_data), 32'h2a);
        bus.accel_id = 4'd2;
        tick();
        bus.accel_read_enable = 1'b1;
        tick();
        bus.accel_read_enable = 1'b0;
        bus.accel_id = 4'd7;
        tick();
        chk("gate_second", 32'(bus.accel_read_data), 32'd42);
        bus.accel_read_enable = 1'b1;
        tick();
        bus.accel_read_enable = 1'b0;
        tick();
        chk("gate_empty", 32'(bus.accel_can_read), 32'h0);

        // Result backpressure and pointer wrap.
        bus.accel_id = 4'd4;
        bus.res_id   = 4'd4;
        pushed = 0;
        for (int c = 0; c < 24 && (pushed < 6 || rq.size() != 0); c++) begin
            bus.res_valid = (pushed < 6);
            bus.res_data  = 16'(16'h0200 + pushed);
            bus.accel_read_enable = (c >= 4 && (c % 2 == 0)) || pushed == 6;
            if (bus.res_valid && rq.size() < RD) pushed++;
            if (c == 4) chk("bp_full", 32'(bus.res_ready), 32'h0);
            tick();
        end
        idle();
        chk("bp_pushed", 32'(pushed), 32'd6);
        chk("bp_empty", 32'(bus.accel_can_read), 32'h0);

        // Reset mid-operation.
        wr(4'd9, 16'hbeef);
        wr(4'd8, 16'hcafe);
        for (int i = 0; i < 3; i++) rs(4'd6, 16'(16'h0300 + i));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_cmd", 32'(bus.cmd_valid), 32'h0);
        chk("mid_err", 32'(bus.error), 32'h0);
        bus.accel_id = 4'd6;
        tick();
        chk("mid_res", 32'(bus.accel_read_data), 32'h0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            bus.accel_id           = 4'($urandom_range(0, 3));
            bus.accel_write_data   = 16'($urandom);
            bus.accel_write_enable = ($urandom_range(0, 2) == 0);
            bus.cmd_ready          = ($urandom_range(0, 2) != 0);
            bus.res_valid          = ($urandom_range(0, 1) == 0);
            bus.res_id             = 4'($urandom_range(0, 3));
            bus.res_data           = 16'($urandom);
            if (rq.size() != 0 && $urandom_range(0, 3) != 0)
                bus.accel_id = rq[0].id;
            bus.accel_read_enable  = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_accel_responder.md
Name: cpu_accel_responder

Overview:
- Accelerator-side endpoint of the CPU accelerator port, servicing accel_id / accel_can_read / accel_can_write / accel_read_enable / accel_read_data / accel_write_enable / accel_write_data.
- CPU writes are queued as {id, data} in a command FIFO and presented to accelerators on a valid/ready stream.
- Accelerator results arrive on a valid/ready stream into a result FIFO; the CPU reads them back only under the id that produced them.
- Sits between cpu and the accelerator cluster (plotter math units).

Parameters:
DATA_WIDTH, 16, width of accel_write_data / accel_read_data / stream data
ID_WIDTH, 4, width of accel_id and stream ids
CMD_DEPTH, 4, command FIFO entries; power of two, >= 2
RES_DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
accel_id  in  ID_WIDTH  accelerator addressed by the current CPU access
accel_can_write  out  1  command FIFO has space
accel_write_enable  in  1  CPU push of {accel_id, accel_write_data}
accel_write_data  in  DATA_WIDTH  command word
accel_can_read  out  1  result FIFO head exists and its id == accel_id
accel_read_enable  in  1  CPU pop of result head
accel_read_data  out  DATA_WIDTH  result FIFO head data (first-word fall-through)
cmd_valid  out  1  command FIFO non-empty
cmd_ready  in  1  accelerator accepts command head
cmd_id  out  ID_WIDTH  head command id
cmd_data  out  DATA_WIDTH  head command data
res_valid  in  1  accelerator offers result
res_ready  out  1  result FIFO has space
res_id  in  ID_WIDTH  result id
res_data  in  DATA_WIDTH  result data
error  out  1  sticky protocol-violation flag

Behaviour:
- Two circular FIFOs, each with read ptr, write ptr and count ($clog2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- All outputs are combinational from registered state plus accel_id; no input-to-output path other than accel_id -> accel_can_read.
- Reset (rst==0 at posedge): both FIFOs empty, pointers 0, error 0. After that edge: accel_can_write=1, accel_can_read=0, cmd_valid=0, res_ready=1, accel_read_data=0 (empty head reads 0). While rst==0, all pushes/pops ignored. Reset mid-operation discards all queued entries.
- Command push: at posedge when accel_write_enable && accel_can_write, store {accel_id, accel_write_data}. Visible on cmd_* next cycle (latency 1).
- Command pop: at posedge when cmd_valid && cmd_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is rejected even with a simultaneous pop (can_write was 0); no bypass.
- accel_can_write = (cmd count != CMD_DEPTH).
- Result push: at posedge when res_valid && res_ready. res_ready = (res count != RES_DEPTH). Same-cycle push+pop when full: push rejected.
- accel_can_read = (res count != 0) && (head id == accel_id). Results are strictly in order: a head for id A blocks reads for id B (no reordering).
- accel_read_data = head data whenever non-empty, regardless of id match; 0 when empty.
- Result pop: at posedge when accel_read_enable && accel_can_read. Visible new head next cycle.
- Protocol violations set error (sticky until reset) and are otherwise ignored (no state change): accel_write_enable while !accel_can_write; accel_read_enable while !accel_can_read.
- Empty/full boundaries: count 0 <-> DEPTH transitions exact; DEPTH consecutive pushes with no pops fill the FIFO; the next cycle shows can_write/res_ready = 0.

Test Plan:
1. Reset: rst=0 for 2 cycles, then 1 -> accel_can_write=1, accel_can_read=0, cmd_valid=0, res_ready=1, error=0; any write during rst=0 leaves cmd_valid=0.
2. Command ordering: cmd_ready=0; write (id 3, 0x0011), (id 5, 0x0022), (id 3, 0x0033), (id 1, 0x0044) -> accel_can_write=0 after the 4th; then cmd_ready=1 -> cmd_* emit (3,0x11), (5,0x22), (3,0x33), (1,0x44) one per cycle, then cmd_valid=0.
3. Full with simultaneous events: cmd FIFO full, cmd_ready=1 and accel_write_enable=1 same cycle -> one pop, push rejected, error=1, count=3.
4. Result id gating: push results (2, 0x002A), (7, 42); accel_id=7 -> accel_can_read=0, accel_read_data=0x002A; accel_id=2 -> can_read=1; pop -> accel_id=7 then reads 42, can_read=1; pop -> can_read=0.
5. Result backpressure/wrap: push 6 results with accel_read_enable popping every other cycle -> res_ready drops to 0 exactly when count=4; data read back in push order across pointer wrap.
6. Reset mid-operation: 2 commands and 3 results queued, rst=0 one cycle -> all FIFOs empty, error cleared, old data never appears afterwards.
